// File: rtl/input_debouncer_pkg.sv
// Shared types and default constants for the input_debouncer slice.
// The optional long-press detector is enabled by defining INPUT_DEBOUNCE_LONG_PRESS_EN.
package input_debouncer_pkg;

  // Debounce FSM state encoding.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHECK_HI  = 2'b01,
    STABLE_HI = 2'b10,
    CHECK_LO  = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LONG_CYCLES     = 16;

  // True while a candidate level change is being qualified.
  function automatic logic is_check(input state_t s);
    logic r;
    case (s)
      CHECK_HI: r = 1'b1;
      CHECK_LO: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Plain flop-chain synchronizer for a single asynchronous bit.
// Reusable for any async input; no logic is placed between stages.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be >= 2");
  end

  // Shift the raw bit through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a bouncy asynchronous input and commits level changes only
// after they hold for DEBOUNCE_CYCLES synchronized cycles. Outputs are all
// registered. Optional long-press pulse: define INPUT_DEBOUNCE_LONG_PRESS_EN.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("input_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("input_debouncer: LONG_CYCLES must be >= 1");
  end

  logic          d_sync_s;
  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic          q_r, q_nx;
  logic          rise_r, rise_nx;
  logic          fall_r, fall_nx;
  logic          busy_r, busy_nx;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_raw),
    .q   (d_sync_s)
  );

  // Next-state and output decode for the debounce FSM.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    q_nx     = q_r;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state_r)
      STABLE_LO: begin
        q_nx = 1'b0;
        if (d_sync_s) begin
          state_nx = CHECK_HI;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx   = CNT_ZERO;
        end
      end
      CHECK_HI: begin
        if (!d_sync_s) begin
          // Glitch rejected: fall back without any pulse.
          state_nx = STABLE_LO;
          cnt_nx   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = STABLE_HI;
          q_nx     = 1'b1;
          rise_nx  = 1'b1;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx   = cnt_r + CNT_ONE;
        end
      end
      STABLE_HI: begin
        q_nx = 1'b1;
        if (!d_sync_s) begin
          state_nx = CHECK_LO;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx   = CNT_ZERO;
        end
      end
      CHECK_LO: begin
        if (d_sync_s) begin
          state_nx = STABLE_HI;
          cnt_nx   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = STABLE_LO;
          q_nx     = 1'b0;
          fall_nx  = 1'b1;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx = STABLE_LO;
        cnt_nx   = CNT_ZERO;
        q_nx     = 1'b0;
      end
    endcase
    busy_nx = is_check(state_nx);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= STABLE_LO;
      cnt_r   <= CNT_ZERO;
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      q_r     <= q_nx;
      rise_r  <= rise_nx;
      fall_r  <= fall_nx;
      busy_r  <= busy_nx;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign busy = busy_r;

`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LP_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LP_ONE  = LW'(1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LP_PRE  = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lp_cnt_r, lp_cnt_nx;
  logic          long_press_r, long_press_nx;

  // Long-press counter: runs in STABLE_HI, holds through a rejected low
  // glitch, clears on a fresh high commit or whenever the level is low.
  always_comb begin
    lp_cnt_nx     = lp_cnt_r;
    long_press_nx = 1'b0;
    if ((state_nx == STABLE_LO) || (state_nx == CHECK_HI)) begin
      lp_cnt_nx = LP_ZERO;
    end else if ((state_r == CHECK_HI) && (state_nx == STABLE_HI)) begin
      lp_cnt_nx = LP_ZERO;
    end else if ((state_r == STABLE_HI) && (lp_cnt_r != LP_MAX)) begin
      lp_cnt_nx     = lp_cnt_r + LP_ONE;
      long_press_nx = (lp_cnt_r == LP_PRE);
    end else begin
      lp_cnt_nx = lp_cnt_r;
    end
  end

  // Long-press registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_cnt_r     <= LP_ZERO;
      long_press_r <= 1'b0;
    end else begin
      lp_cnt_r     <= lp_cnt_nx;
      long_press_r <= long_press_nx;
    end
  end

  assign long_press = long_press_r;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus random
// bounce trains compared against a run-length reference model.
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 16;
`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_raw = 1'b0;
  logic q, rise, fall, busy, lp_obs;

  int errors = 0;
  int checks = 0;

  // Reference model state: sampled-input history and run length of
  // consecutive samples that disagree with the committed level.
  logic sh [SYNC];
  logic m_q, m_rise, m_fall, m_busy, m_lp;
  int   run, lpc;

  always #5 clk = ~clk;

  input_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .d_raw (d_raw),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
    ,
    .long_press (lp_obs)
`endif
  );

`ifndef INPUT_DEBOUNCE_LONG_PRESS_EN
  assign lp_obs = 1'b0;
`endif

  // Drive one cycle of input, advance the model with the same edge.
  task automatic step(input logic d, input logic r);
    logic ds;
    logic was_hi;
    d_raw = d;
    rst   = r;
    @(posedge clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_lp   = 1'b0;
    if (r) begin
      for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
      m_q = 1'b0; run = 0; lpc = 0; m_busy = 1'b0;
    end else begin
      ds = sh[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = d;
      was_hi = m_q && (run == 0);
      if (ds != m_q) begin
        run++;
        if (run == DEB) begin
          m_q = ds; run = 0; m_rise = ds; m_fall = !ds;
        end
      end else begin
        run = 0;
      end
      if (m_rise || m_fall || !m_q) lpc = 0;
      else if (was_hi && lpc < LONG) begin
        lpc++;
        m_lp = LP_EN && (lpc == LONG);
      end
      m_busy = (run != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if ({q, rise, fall, busy, lp_obs} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: got q/rise/fall/busy/lp=%b required 00000",
               {q, rise, fall, busy, lp_obs});
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_v;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      exp_v = {(k >= 6), (k == 6), 1'b0, (k >= 3 && k <= 5)};
      checks++;
      if ({q, rise, fall, busy} !== exp_v) begin
        errors++;
        $display("FAIL latency_edge%0d: got q/rise/fall/busy=%b required %b",
                 k, {q, rise, fall, busy}, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    int rises;
    rises = 0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step((k < 3) ? 1'b1 : 1'b0, 1'b0);
      if (rise) rises++;
      checks++;
      if ({q, rise, fall, busy, lp_obs} !== {m_q, m_rise, m_fall, m_busy, m_lp}) begin
        errors++;
        $display("FAIL glitch_cycle%0d: got %b model %b", k,
                 {q, rise, fall, busy, lp_obs}, {m_q, m_rise, m_fall, m_busy, m_lp});
      end
    end
    checks++;
    if (rises != 0 || q !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got rises=%0d q=%b busy=%b required 0 0 0",
               rises, q, busy);
    end
  endtask

  task automatic test_min_pulse();
    int rises, falls, rise_at, fall_at;
    rises = 0; falls = 0; rise_at = -1; fall_at = -1;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      step((k <= 4) ? 1'b1 : 1'b0, 1'b0);
      if (rise) begin rises++; rise_at = k; end
      if (fall) begin falls++; fall_at = k; end
    end
    checks++;
    if (rises != 1 || rise_at != 6) begin
      errors++;
      $display("FAIL min_pulse_rise: got count=%0d at=%0d required 1 at 6", rises, rise_at);
    end
    checks++;
    if (falls != 1 || fall_at != 10 || q !== 1'b0) begin
      errors++;
      $display("FAIL min_pulse_fall: got count=%0d at=%0d q=%b required 1 at 10 q=0",
               falls, fall_at, q);
    end
  endtask

  task automatic test_reset_mid();
    int q_at;
    q_at = -1;
    step(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%b required 1", busy);
    end
    step(1'b1, 1'b1);
    checks++;
    if ({q, rise, fall, busy, lp_obs} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_mid_clear: got %b required 00000", {q, rise, fall, busy, lp_obs});
    end
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0);
      if (q === 1'b1 && q_at < 0) q_at = k;
    end
    checks++;
    if (q_at != 6) begin
      errors++;
      $display("FAIL reset_mid_requal: got q rise at edge %0d required 6", q_at);
    end
  endtask

  task automatic test_bounce();
    logic train [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                         1'b1, 1'b1, 1'b1, 1'b1};
    int rises, rise_at;
    rises = 0; rise_at = -1;
    step(1'b0, 1'b1);
    for (int k = 0; k < 13; k++) begin
      step(train[k], 1'b0);
      if (rise) begin rises++; rise_at = k + 1; end
      checks++;
      if ({q, rise, fall, busy, lp_obs} !== {m_q, m_rise, m_fall, m_busy, m_lp}) begin
        errors++;
        $display("FAIL bounce_cycle%0d: got %b model %b", k,
                 {q, rise, fall, busy, lp_obs}, {m_q, m_rise, m_fall, m_busy, m_lp});
      end
    end
    checks++;
    if (rises != 1 || rise_at != 11) begin
      errors++;
      $display("FAIL bounce_rise: got count=%0d at=%0d required 1 at 11", rises, rise_at);
    end
  endtask

  task automatic test_random();
    int n;
    logic lvl;
    int len;
    n = 0;
    step(1'b0, 1'b1);
    while (n < 600) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step(lvl, ($urandom_range(0, 150) == 0) ? 1'b1 : 1'b0);
        n++;
        checks++;
        if ({q, rise, fall, busy, lp_obs} !== {m_q, m_rise, m_fall, m_busy, m_lp}) begin
          errors++;
          $display("FAIL random_cycle%0d: got q/rise/fall/busy/lp=%b model %b", n,
                   {q, rise, fall, busy, lp_obs}, {m_q, m_rise, m_fall, m_busy, m_lp});
        end
      end
    end
  endtask

`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
  task automatic test_long_press();
    int lps, lp_at;
    // Plain hold: pulse 16 cycles after q rises (edge 6), once only.
    lps = 0; lp_at = -1;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0);
      if (lp_obs) begin lps++; lp_at = k; end
    end
    checks++;
    if (lps != 1 || lp_at != 22) begin
      errors++;
      $display("FAIL long_press_hold: got count=%0d at=%0d required 1 at 22", lps, lp_at);
    end
    // Two-cycle low glitch mid-hold: counter holds, pulse delayed by 2.
    lps = 0; lp_at = -1;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step((k == 15 || k == 16) ? 1'b0 : 1'b1, 1'b0);
      if (lp_obs) begin lps++; lp_at = k; end
      checks++;
      if ({q, rise, fall, busy, lp_obs} !== {m_q, m_rise, m_fall, m_busy, m_lp}) begin
        errors++;
        $display("FAIL long_press_glitch_cycle%0d: got %b model %b", k,
                 {q, rise, fall, busy, lp_obs}, {m_q, m_rise, m_fall, m_busy, m_lp});
      end
    end
    checks++;
    if (lps != 1 || lp_at != 24) begin
      errors++;
      $display("FAIL long_press_glitch: got count=%0d at=%0d required 1 at 24", lps, lp_at);
    end
    // Release before the window expires: no pulse.
    lps = 0;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step((k <= 14) ? 1'b1 : 1'b0, 1'b0);
      if (lp_obs) lps++;
    end
    checks++;
    if (lps != 0) begin
      errors++;
      $display("FAIL long_press_early_release: got count=%0d required 0", lps);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
    m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_lp = 1'b0;
    run = 0; lpc = 0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_min_pulse();
    test_reset_mid();
    test_bounce();
`ifdef INPUT_DEBOUNCE_LONG_PRESS_EN
    test_long_press();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
